// File: rtl/signed_bin2bcd_seq_pkg.sv
// Shared types and constants for the signed binary to sign-magnitude BCD converter.
package signed_bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGITS     = 3;
    localparam int         BCD_W          = 12;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/signed_bin2bcd_seq_bcd_digit_adjust.sv
// Combinational double-dabble nibble corrector: adds 3 to any digit of 5 or more
// so that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import signed_bin2bcd_seq_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= ADD3_THRESHOLD) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/signed_bin2bcd_seq.sv
// Sequential signed binary to sign-magnitude BCD converter (shift-and-add-3).
// Converts once after reset and whenever the input differs from the last converted value.
module signed_bin2bcd_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] binary,
    output logic         sign,
    output logic [3:0]   hundreds,
    output logic [3:0]   tens,
    output logic [3:0]   ones,
    output logic         data_ready
);
    import signed_bin2bcd_seq_pkg::*;

    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [N-1:0] CNT_LOAD = N'(N);

    state_t             state;
    state_t             state_next;
    logic [N-1:0]       last_val;
    logic [N-1:0]       mag_shift;
    logic [N-1:0]       cnt;
    logic               pending_first;
    logic               sign_cap;
    logic [BCD_W-1:0]   bcd_acc;
    logic [BCD_W-1:0]   bcd_adj;
    logic               start;

    assign start = (state == IDLE) && (pending_first || (binary != last_val));

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .nibble   (bcd_acc[4*i +: 4]),
            .adjusted (bcd_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            // the edge that takes cnt from 1 to 0 is the last shift
            SHIFT:   if (cnt == ONE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val      <= '0;
            pending_first <= 1'b1;
            sign_cap      <= 1'b0;
            mag_shift     <= '0;
            bcd_acc       <= '0;
            cnt           <= '0;
            sign          <= 1'b0;
            hundreds      <= 4'd0;
            tens          <= 4'd0;
            ones          <= 4'd0;
            data_ready    <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_val      <= binary;
                        pending_first <= 1'b0;
                        sign_cap      <= binary[N-1];
                        // two's complement negate as unsigned; the most negative value maps to 2^(N-1)
                        mag_shift     <= binary[N-1] ? (~binary + ONE) : binary;
                        bcd_acc       <= '0;
                        cnt           <= CNT_LOAD;
                    end
                end
                SHIFT: begin
                    {bcd_acc, mag_shift} <= {bcd_adj, mag_shift} << 1;
                    cnt                  <= cnt - ONE;
                end
                DONE: begin
                    sign       <= sign_cap;
                    hundreds   <= bcd_acc[11:8];
                    tens       <= bcd_acc[7:4];
                    ones       <= bcd_acc[3:0];
                    data_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_bin2bcd_seq.sv
// Directed bench for signed_bin2bcd_seq with a decimal-arithmetic reference model
// and a per-cycle output monitor.
module tb_signed_bin2bcd_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] binary;
    logic         sign;
    logic [3:0]   hundreds;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic         data_ready;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int cur_sign = 0, cur_h = 0, cur_t = 0, cur_o = 0;
    int pulse_count = 0;

    always #5 clk = ~clk;

    signed_bin2bcd_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .binary     (binary),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .data_ready (data_ready)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: decimal digits of |v| plus sign, using plain integer arithmetic.
    function automatic void model(input int v, output int s, output int h, output int t, output int o);
        int mag;
        s   = (v < 0) ? 1 : 0;
        mag = (v < 0) ? -v : v;
        h   = mag / 100;
        t   = (mag / 10) % 10;
        o   = mag % 10;
    endfunction

    // Monitor: every cycle, outputs either update to the next queued result on a
    // data_ready pulse, or hold the previous result exactly.
    initial begin
        int prev_dr;
        int s, h, t, o, v;
        prev_dr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_data_ready", int'(data_ready), 0);
                chk("reset_digits", {28'd0, hundreds} * 100 + {28'd0, tens} * 10 + {28'd0, ones}, 0);
                chk("reset_sign", int'(sign), 0);
                cur_sign = 0; cur_h = 0; cur_t = 0; cur_o = 0;
                prev_dr = 0;
            end else if (data_ready) begin
                pulse_count++;
                chk("no_double_pulse", prev_dr, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    v = exp_q.pop_front();
                    model(v, s, h, t, o);
                    chk("sign", int'(sign), s);
                    chk("hundreds", int'(hundreds), h);
                    chk("tens", int'(tens), t);
                    chk("ones", int'(ones), o);
                    cur_sign = s; cur_h = h; cur_t = t; cur_o = o;
                end
                prev_dr = 1;
            end else begin
                if (int'(sign) != cur_sign || int'(hundreds) != cur_h ||
                    int'(tens) != cur_t || int'(ones) != cur_o)
                    chk("hold_outputs", {int'(sign), int'(hundreds), int'(tens), int'(ones)} != 0 ? 1 : 0, -1);
                prev_dr = 0;
            end
        end
    end

    // Counts edges from the current negedge until data_ready is seen (0 on timeout).
    task automatic wait_ready(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (data_ready) begin
                k = i;
                break;
            end
        end
        if (k == 0) chk("ready_timeout", 0, 1);
    endtask

    task automatic convert(input int v, input string name);
        int k;
        @(negedge clk);
        binary = N'(v);
        exp_q.push_back(v);
        wait_ready(k);
        // sample edge + N shift edges + done edge
        chk({name, "_latency"}, k, N + 2);
    endtask

    initial begin
        int s, h, t, o, k, pulses_before;

        // Pin the model with hand-computed decimal conversions.
        model(127, s, h, t, o);  chk("model_127", s*1000 + h*100 + t*10 + o, 127);
        model(-128, s, h, t, o); chk("model_m128", s*1000 + h*100 + t*10 + o, 1128);
        model(-37, s, h, t, o);  chk("model_m37", s*1000 + h*100 + t*10 + o, 1037);

        rst    = 1'b0;
        binary = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // First conversion after reset, of zero.
        exp_q.push_back(0);
        rst = 1'b0;
        wait_ready(k);
        chk("first_latency", k, N + 2);
        pulses_before = pulse_count;
        repeat (50) @(negedge clk);
        chk("held_input_no_pulse", pulse_count, pulses_before);

        convert(127, "p127");
        chk("lit_127_h", int'(hundreds), 1);
        chk("lit_127_t", int'(tens), 2);
        chk("lit_127_o", int'(ones), 7);

        convert(-128, "m128");
        chk("lit_m128_sign", int'(sign), 1);
        chk("lit_m128_o", int'(ones), 8);

        convert(-1, "m1");
        chk("lit_m1", int'(sign)*1000 + int'(hundreds)*100 + int'(tens)*10 + int'(ones), 1001);

        convert(-37, "m37");
        convert(0, "zero");
        convert(-127, "m127");

        // Input change three cycles after the sample edge is deferred, not lost.
        @(negedge clk);
        binary = N'(45);
        exp_q.push_back(45);
        exp_q.push_back(99);
        pulses_before = pulse_count;
        repeat (4) @(posedge clk);
        @(negedge clk);
        binary = N'(99);
        for (int i = 0; i < 60 && pulse_count < pulses_before + 2; i++) @(negedge clk);
        chk("mid_change_pulses", pulse_count - pulses_before, 2);
        chk("lit_99", int'(hundreds)*100 + int'(tens)*10 + int'(ones), 99);

        // Reset four cycles into a conversion of 100.
        @(negedge clk);
        binary = N'(100);
        exp_q.push_back(100);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_digits", int'(hundreds)*100 + int'(tens)*10 + int'(ones), 0);
        chk("async_rst_ready", int'(data_ready), 0);
        repeat (3) @(negedge clk);
        exp_q.push_back(100);
        rst = 1'b0;
        wait_ready(k);
        chk("post_rst_latency", k, N + 2);
        chk("lit_100", int'(hundreds)*100 + int'(tens)*10 + int'(ones), 100);

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
